// File: rtl/frame_stream_arbiter.sv
// frame_stream_arbiter: round-robin, frame-granular arbiter that shares a
// single AXI-Stream sink among NUM_SOURCES sources. A grant is held from the
// first beat until the TLast beat is accepted. Includes a small config
// register file (ENABLE, PRIORITY, STATUS, per-source FRAMECOUNT).
// Optional feature: define FRAME_ARB_PRIORITY_EN to add the PRIORITY mask.
//
// state | meaning
// IDLE  | no grant held; arbitrate among enabled, valid sources
// BUSY  | grant held; source `grant` is passed straight through

module frame_stream_arbiter #(
    parameter int NUM_SOURCES = 4
) (
    input  logic                     masterClock,
    input  logic                     resetN,
    input  logic [32*NUM_SOURCES-1:0] srcData,
    input  logic [NUM_SOURCES-1:0]   srcTValid,
    output logic [NUM_SOURCES-1:0]   srcTReady,
    input  logic [NUM_SOURCES-1:0]   srcTLast,
    output logic [31:0]              dataOut,
    output logic                     dataOutTValid,
    input  logic                     dataOutTReady,
    output logic                     dataOutTLast,
    input  logic [31:0]              configRegisterAddress,
    input  logic [31:0]              configRegisterDataIn,
    input  logic                     configRegisterWriteEnable,
    output logic [31:0]              configRegisterDataOut
);

    localparam int IDX_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                   state_q, state_d;
    idx_t                     grant_q, grant_d;
    idx_t                     last_grant_q, last_grant_d;
    logic [NUM_SOURCES-1:0]   enable_q;
    logic [NUM_SOURCES-1:0]   prio_q;
    logic [31:0]              framecount_q [NUM_SOURCES];
    logic [31:0]              rdata_d, rdata_q;

    logic [NUM_SOURCES-1:0]   req;
    logic                     winner_found;
    idx_t                     winner;
    idx_t                     cand;
    logic                     frame_end;
    logic                     unused_cfg;

    // Only the low NUM_SOURCES data bits are ever stored.
    assign unused_cfg = &{1'b0, configRegisterDataIn[31:NUM_SOURCES]};

    // Request masking and round-robin search starting just after lastGrant.
    always_comb begin
        req          = srcTValid & enable_q;
`ifdef FRAME_ARB_PRIORITY_EN
        if (|(req & prio_q)) begin
            req = req & prio_q;
        end
`endif
        winner_found = 1'b0;
        winner       = '0;
        cand         = '0;
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            cand = idx_t'((int'(last_grant_q) + k) % NUM_SOURCES);
            if (!winner_found && req[cand]) begin
                winner_found = 1'b1;
                winner       = cand;
            end
        end
    end

    // Next-state logic and the zero-latency passthrough of the granted source.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        srcTReady     = '0;
        dataOut       = '0;
        dataOutTValid = 1'b0;
        dataOutTLast  = 1'b0;
        frame_end     = 1'b0;
        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    grant_d = winner;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                dataOut            = srcData[32*int'(grant_q) +: 32];
                dataOutTValid      = srcTValid[grant_q];
                dataOutTLast       = srcTLast[grant_q];
                srcTReady[grant_q] = dataOutTReady;
                if (srcTValid[grant_q] && dataOutTReady && srcTLast[grant_q]) begin
                    frame_end    = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, grant and last-grant registers.
    always_ff @(posedge masterClock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= idx_t'(NUM_SOURCES - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Writable config: ENABLE and (optionally) PRIORITY masks.
    always_ff @(posedge masterClock or negedge resetN) begin
        if (!resetN) begin
            enable_q <= '1;
            prio_q   <= '0;
        end else if (configRegisterWriteEnable) begin
            if (configRegisterAddress == 32'd0) begin
                enable_q <= configRegisterDataIn[NUM_SOURCES-1:0];
            end
`ifdef FRAME_ARB_PRIORITY_EN
            if (configRegisterAddress == 32'd1) begin
                prio_q <= configRegisterDataIn[NUM_SOURCES-1:0];
            end
`endif
        end
    end

    // Per-source frame counters; a write-clear beats a same-cycle increment.
    always_ff @(posedge masterClock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                framecount_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                if (configRegisterWriteEnable && configRegisterAddress == 32'(4 + i)) begin
                    framecount_q[i] <= '0;
                end else if (frame_end && grant_q == idx_t'(i)) begin
                    framecount_q[i] <= framecount_q[i] + 32'd1;
                end
            end
        end
    end

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        rdata_d = '0;
        if (configRegisterAddress == 32'd0) begin
            rdata_d[NUM_SOURCES-1:0] = enable_q;
        end
`ifdef FRAME_ARB_PRIORITY_EN
        if (configRegisterAddress == 32'd1) begin
            rdata_d[NUM_SOURCES-1:0] = prio_q;
        end
`endif
        if (configRegisterAddress == 32'd2) begin
            rdata_d[0]    = (state_q == BUSY);
            rdata_d[6:4]  = 3'(grant_q);
            rdata_d[10:8] = 3'(last_grant_q);
        end
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (configRegisterAddress == 32'(4 + i)) begin
                rdata_d = framecount_q[i];
            end
        end
    end

    // Registered read data, one cycle after the address.
    always_ff @(posedge masterClock or negedge resetN) begin
        if (!resetN) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign configRegisterDataOut = rdata_q;

endmodule
